// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central pipeline sequencer for the 5-stage core.
// Drives the PC and pipeline-register enables/flushes. It freezes the pipe on
// outstanding data-memory accesses (bounded by DM_TIMEOUT), inserts load-use
// bubbles and squashes the wrong path on taken branches.
// Priority: reset > freeze > branch > load-use > normal.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   id_rs1/id_rs2       source registers of the ID instruction (id_uses_rs2 qualifies rs2)
//   ex_rd, ex_mem_read  destination / load flag of the EX instruction
//   ex_branch_taken     branch in EX resolved taken
//   mem_req, dm_ready   data-memory access in MEM and its completion
//   *_en, *_flush       register load enables and bubble loads (flush wins)
//   dm_wait             pipeline frozen on data memory
//   dm_err              sticky data-memory timeout flag
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds the perf_dm_stall,
// perf_lu_stall and perf_br_flush 32-bit wrapping counters.
module pipe_hazard_ctrl #(
    parameter int unsigned DM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        dm_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        dm_wait,
    output logic        dm_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_dm_stall,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_br_flush
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(DM_TIMEOUT);
    localparam logic TMO_EN = (DM_TIMEOUT != 0);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_pending;
    logic             freeze;
    logic             timeout_hit;
    logic             lu_hazard;
    logic             br_sel;
    logic             lu_sel;

    // Hazard detection
    assign mem_pending = mem_req & ~dm_ready;
    assign freeze      = mem_pending & (~TMO_EN | (wait_cnt < TMO_VAL));
    assign timeout_hit = mem_pending & TMO_EN & (wait_cnt == TMO_VAL);
    assign lu_hazard   = ex_mem_read & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign br_sel      = ~rst & ~freeze & ex_branch_taken;
    assign lu_sel      = ~rst & ~freeze & ~ex_branch_taken & lu_hazard;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state: any non-freeze cycle (ready, timeout, or mem_req dropped) releases
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        unique case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            WAIT: begin
                if (freeze) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline control outputs (combinational, zero-cycle latency)
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        dm_wait      = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            // WB instruction retires once, then MEM_WB holds bubbles
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            dm_wait      = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_err <= 1'b0;
        end else if (timeout_hit) begin
            dm_err <= 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Performance counters, wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dm_stall <= '0;
            perf_lu_stall <= '0;
            perf_br_flush <= '0;
        end else begin
            if (freeze) perf_dm_stall <= perf_dm_stall + 32'd1;
            if (lu_sel) perf_lu_stall <= perf_lu_stall + 32'd1;
            if (br_sel) perf_br_flush <= perf_br_flush + 32'd1;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = br_sel ^ lu_sel;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. It drives the enable and flush controls of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It freezes the pipeline while a data-memory access is outstanding, inserts load-use bubbles, squashes wrong-path instructions on taken branches, and bounds memory waits with a timeout.

## Interface
- DM_TIMEOUT, 16: maximum consecutive frozen cycles per data-memory access, 1..255; 0 disables the timeout.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM instruction accesses data memory this cycle.
- dm_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a NOP/bubble at the next edge; flush has priority over enable.
- dm_wait  out  1  pipeline frozen on data memory (state is WAIT or entering it).
- dm_err  out  1  sticky; a data-memory access hit the timeout.

## Operation
- FSM states: RUN, WAIT. wait_cnt is 8-bit and counts frozen cycles of the current access.
- freeze = mem_req & ~dm_ready & (DM_TIMEOUT==0 | wait_cnt < DM_TIMEOUT).
- timeout_hit = mem_req & ~dm_ready & DM_TIMEOUT!=0 & wait_cnt == DM_TIMEOUT.
- RUN → WAIT when freeze; wait_cnt becomes 1.
- WAIT stays in WAIT while freeze; wait_cnt increments.
- WAIT → RUN on dm_ready or timeout_hit; wait_cnt clears to 0.
- WAIT → RUN if mem_req drops; treated as a completed access.
- timeout_hit sets dm_err; dm_err clears only on rst.
- Freeze outputs: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en = 1; mem_wb_flush = 1 (the WB instruction retires once, then bubbles); dm_wait = 1. Branch and load-use logic are ignored.
- Release cycle (dm_ready or timeout_hit): all enables are 1 and MEM_WB captures the result. Branch and load-use logic are evaluated normally.
- Branch, when not frozen: ex_branch_taken → if_id_flush = 1, id_ex_flush = 1, all enables 1 (PC loads the target). Branch overrides load-use.
- Load-use, when not frozen and no branch: ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1 | (id_uses_rs2 & ex_rd == id_rs2)) → pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1, mem_wb_en = 1.
- Otherwise all enables are 1 and all flushes are 0.
- Priority: freeze > branch > load-use > normal.

## Timing
- All control outputs are combinational from the inputs and registered state, with zero-cycle latency into the current cycle's register edge. Only state, wait_cnt and dm_err are registered.
- During rst: every *_en = 0, every *_flush = 1, dm_wait = 0. After the rst edge: state = RUN, wait_cnt = 0, dm_err = 0.
- rst asserted mid-WAIT: the same edge forces RUN, wait_cnt = 0, dm_err = 0.
- Single-cycle memory (mem_req & dm_ready in the same cycle): no freeze.
- A new mem_req immediately after a release starts a fresh count from 0.
- Load-use stall lasts exactly 1 cycle, since the load moves to MEM.
- A branch flush costs 2 bubbles.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: adds three 32-bit wrapping output counters, cleared by rst:
  - perf_dm_stall: frozen cycles.
  - perf_lu_stall: load-use bubbles.
  - perf_br_flush: taken-branch flushes.
- Each counter increments in the cycle its condition drives the outputs.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles → all en = 0, all flush = 1; after release, state RUN, dm_err = 0, all en = 1 with idle inputs.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5 → 1 cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1. With ex_rd = 0 → no stall. With id_rs2 = 5 and id_uses_rs2 = 0 → no stall.
- Memory wait: mem_req = 1, dm_ready low for 3 cycles then high → dm_wait = 1 for 3 cycles with mem_wb_flush = 1; the 4th cycle has all en = 1 and dm_err = 0.
- Timeout with DM_TIMEOUT = 4: dm_ready never asserts → 4 frozen cycles, release on the 5th cycle, dm_err = 1 and sticky until rst.
- Priority: ex_branch_taken together with a load-use match → if_id_flush = id_ex_flush = 1, pc_en = 1. The same inputs during freeze → freeze outputs only.
- rst asserted at wait_cnt = 2 → next cycle RUN, wait_cnt = 0. With PIPE_HAZARD_CTRL_PERF_EN defined, perf_dm_stall = 0.
